// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle sequencer FETCH/DECODE/EXEC/MEM/WB with ack timeout
// Optional retired-instruction counter enabled by defining INSTRET_CNT_EN.
module multicycle_ctrl #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam int          TW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic        TO_EN   = (ACK_TIMEOUT > 0);
  localparam logic [TW-1:0] TO_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic          err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          req_wait, timeout;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // Req only drops between requests, so clearing while idle equals clearing on its rising edge.
  assign req_wait = ((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);
  assign timeout  = TO_EN && req_wait && (cnt_q == TO_LAST);
  assign cnt_d    = (req_wait && TO_EN) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 2'b00;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_imm = (opcode != OP_OP) && (opcode != OP_BRANCH);
        if (opcode == OP_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? 2'b01 : 2'b00;
          state_d = S_FETCH;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ack) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        case (opcode)
          OP_LOAD:          wb_sel = 2'b01;
          OP_JAL, OP_JALR:  wb_sel = 2'b10;
          OP_LUI:           wb_sel = 2'b11;
          default:          wb_sel = 2'b00;
        endcase
        if (opcode == OP_JAL)       pc_sel = 2'b01;
        else if (opcode == OP_JALR) pc_sel = 2'b10;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // A stop request only takes effect once the current instruction retires.
    if (pc_we && halt_req) state_d = S_HALT;
    if (rst) begin
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      alu_src_imm = 1'b0;
      reg_we      = 1'b0;
      wb_sel      = 2'b00;
      pc_we       = 1'b0;
      pc_sel      = 2'b00;
    end
  end

  assign halted = (state_q == S_HALT);
  assign err    = err_q;
  assign state  = state_q;

`ifdef INSTRET_CNT_EN
  logic [CNT_W-1:0] instret_q;
  always_ff @(posedge clk) begin
    if (rst)        instret_q <= '0;
    else if (pc_we) instret_q <= instret_q + 1'b1;
  end
  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - vector table plus corner sequences for multicycle_ctrl
module tb_multicycle_ctrl;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             branch_taken, halt_req, imem_ack, dmem_ack;
  logic             imem_req, ir_we, dmem_req, dmem_we, alu_src_imm, reg_we, pc_we;
  logic [1:0]       wb_sel, pc_sel;
  logic             halted, err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl #(.ACK_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .halt_req(halt_req), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_sel(pc_sel), .halted(halted), .err(err), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic        taken;
    int          idly;
    int          ddly;
    int          cyc;
    logic [1:0]  psel;
    logic [1:0]  wsel;
    logic        rw;
    logic        dwe;
    int          dreq;
    logic        imm;
    logic [47:0] trace;
  } vec_t;

  typedef struct {
    logic [1:0] psel;
    logic [1:0] wsel;
    logic       rw;
    int         cyc;
  } res_t;

  res_t exp_q[$];
  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;
  int   n_ret    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_instret();
`ifdef INSTRET_CNT_EN
    chk("instret", 64'(instret), 64'(n_ret));
`else
    chk("instret", 64'(instret), 64'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
    opcode = 7'd0; branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_ret = 0;
    exp_q.delete();
    #1;
  endtask

  task automatic run_instr(input vec_t v, input logic hreq, input logic [2:0] nxt);
    int cyc = 0, iw = 0, dw = 0, dreq = 0, irw = 0;
    logic dwe = 1'b0, imm = 1'b0, rws = 1'b0, got = 1'b0;
    logic [47:0] tr = '0;
    res_t e;
    e.psel = v.psel; e.wsel = v.wsel; e.rw = v.rw; e.cyc = v.cyc;
    exp_q.push_back(e);
    opcode = v.op; branch_taken = v.taken; halt_req = hreq;
    while (!got && cyc < 64) begin
      @(negedge clk);
      imem_ack = imem_req && (iw >= v.idly);
      dmem_ack = dmem_req && (dw >= v.ddly);
      #1;
      cyc++;
      if (imem_req && !imem_ack) iw++;
      if (dmem_req && !dmem_ack) dw++;
      tr = {tr[44:0], state};
      if (dmem_req) dreq++;
      if (dmem_req && dmem_we) dwe = 1'b1;
      if (ir_we) irw++;
      if (reg_we) rws = 1'b1;
      if (state == 3'd2 && alu_src_imm) imm = 1'b1;
      if (pc_we) begin
        got = 1'b1;
        n_ret++;
        e = exp_q.pop_front();
        chk("pc_sel", 64'(pc_sel), 64'(e.psel));
        chk("wb_sel", 64'(wb_sel), 64'(e.wsel));
        chk("reg_we_at_retire", 64'(reg_we), 64'(e.rw));
        chk("cycles", 64'(cyc), 64'(e.cyc));
      end
    end
    chk("retired", 64'(got), 64'd1);
    if (!got) exp_q.delete();
    chk("state_trace", 64'(tr), 64'(v.trace));
    chk("reg_we_seen", 64'(rws), 64'(v.rw));
    chk("dmem_we_seen", 64'(dwe), 64'(v.dwe));
    chk("dmem_req_cycles", 64'(dreq), 64'(v.ddly + ((v.op == 7'b0000011 || v.op == 7'b0100011) ? 1 : 0) - ((v.op == 7'b0000011 || v.op == 7'b0100011) ? 0 : v.ddly)));
    chk("alu_src_imm", 64'(imm), 64'(v.imm));
    chk("ir_we_count", 64'(irw), 64'd1);
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
    #1;
    chk("next_state", 64'(state), 64'(nxt));
    chk_instret();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{7'b0110011, 1'b0, 0, 0, 4, 2'd0, 2'd0, 1'b1, 1'b0, 0, 1'b0, 48'o0124};
    vecs[1] = '{7'b0000011, 1'b0, 0, 3, 8, 2'd0, 2'd1, 1'b1, 1'b0, 4, 1'b1, 48'o01233334};
    vecs[2] = '{7'b1100011, 1'b1, 0, 0, 3, 2'd1, 2'd0, 1'b0, 1'b0, 0, 1'b0, 48'o012};
    vecs[3] = '{7'b1100011, 1'b0, 0, 0, 3, 2'd0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 48'o012};
    vecs[4] = '{7'b1101111, 1'b0, 2, 0, 6, 2'd1, 2'd2, 1'b1, 1'b0, 0, 1'b1, 48'o000124};
    vecs[5] = '{7'b1100111, 1'b0, 0, 0, 4, 2'd2, 2'd2, 1'b1, 1'b0, 0, 1'b1, 48'o0124};
    vecs[6] = '{7'b0110111, 1'b0, 0, 0, 4, 2'd0, 2'd3, 1'b1, 1'b0, 0, 1'b1, 48'o0124};
    vecs[7] = '{7'b0010111, 1'b0, 1, 0, 5, 2'd0, 2'd0, 1'b1, 1'b0, 0, 1'b1, 48'o00124};
    vecs[8] = '{7'b0100011, 1'b0, 0, 2, 6, 2'd0, 2'd0, 1'b0, 1'b1, 3, 1'b1, 48'o012333};
    vecs[9] = '{7'b0010011, 1'b0, 0, 0, 4, 2'd0, 2'd0, 1'b1, 1'b0, 0, 1'b1, 48'o0124};

    do_reset();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_imem_req", 64'(imem_req), 64'd1);
    chk("rst_strobes", 64'({ir_we, dmem_req, dmem_we, alu_src_imm, reg_we, wb_sel, pc_we, pc_sel}), 64'd0);
    chk("rst_flags", 64'({halted, err}), 64'd0);
    chk_instret();

    for (int i = 0; i < 10; i++) run_instr(vecs[i], 1'b0, 3'd0);

    // illegal opcode halts after decode; only reset leaves HALT
    do_reset();
    opcode = 7'h7F;
    @(negedge clk); imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); #1;
    chk("illegal_state", 64'(state), 64'd7);
    chk("illegal_flags", 64'({halted, err}), 64'b11);
    chk("illegal_imem_req", 64'(imem_req), 64'd0);
    opcode = 7'b0110011; imem_ack = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("illegal_sticky", 64'({state, halted, err}), 64'({3'd7, 2'b11}));
    imem_ack = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("illegal_cleared", 64'({state, halted, err, imem_req}), 64'({3'd0, 3'b001}));

    // instruction fetch never acknowledged
    do_reset();
    n = imem_req ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (imem_req) n++;
      else break;
    end
    chk("timeout_req_cycles", 64'(n), 64'd16);
    chk("timeout_flags", 64'({state, halted, err}), 64'({3'd7, 2'b11}));
    @(negedge clk); #1;
    chk("timeout_req_low", 64'({imem_req, dmem_req}), 64'd0);

    // halt_req held through a store: it completes, then HALT without error
    do_reset();
    begin
      vec_t sv;
      sv = '{7'b0100011, 1'b0, 0, 0, 4, 2'd0, 2'd0, 1'b0, 1'b1, 1, 1'b1, 48'o0123};
      run_instr(sv, 1'b1, 3'd7);
    end
    chk("halt_req_flags", 64'({halted, err}), 64'b10);

    // reset in the middle of a stalled load
    do_reset();
    opcode = 7'b0000011;
    @(negedge clk); imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    n = 0;
    while (state != 3'd3 && n < 10) begin @(negedge clk); n++; end
    chk("mid_rst_reached_mem", 64'(state), 64'd3);
    rst = 1'b1; #1;
    chk("mid_rst_no_strobes", 64'({imem_req, dmem_req, dmem_we, reg_we, pc_we, ir_we}), 64'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("mid_rst_fetch", 64'({state, imem_req, halted, err}), 64'({3'd0, 3'b100}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
